// File: rtl/display_pkg.sv
// Shared types and sizing for the display path (mux, BCD converter, 7-seg).
// Provides the converter state enum and the default display widths.
package display_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } conv_state_t;

    localparam int DISP_WIDTH = 16;
    localparam int BCD_DIGITS = 5;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5..9 gets +3 before a shift.
// Ports: digit_i (4-bit digit in), digit_o (4-bit adjusted digit out).
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Ports: clk, reset (sync, active-high), start/bin_in request, busy, done
// (one-cycle pulse), bcd_out (packed BCD, ones digit in [3:0], held).
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH  = DISP_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    conv_state_t   state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0] scratch_q, scratch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] bcd_q, bcd_d;
    logic          done_q, done_d;

    logic [SW-1:0] adj;
    logic [SW-1:0] scratch_sh;
    logic          carry;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // carry is the bit leaving the top digit; it is always zero for a
    // legal WIDTH/DIGITS pair, and is recycled into the vacated low bit.
    assign {carry, scratch_sh} = {adj, shift_q[WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = scratch_sh;
                shift_d   = {shift_q[WIDTH-2:0], carry};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bcd_d   = scratch_sh;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == CONVERT);
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Drives conversions and compares against hand-computed BCD values.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;

    int n_chk;
    int n_pass;

    bin_to_bcd_seq #(
        .WIDTH  (16),
        .DIGITS (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion, optionally poke bin_in/start while busy at
    // cycle poke_k, wait for done, then watch tail idle cycles.
    task automatic run_conv(input string tag, input logic [15:0] val,
                            input logic [19:0] exp, input int poke_k,
                            input logic [15:0] poke_val,
                            input logic poke_start, input int tail);
        int k;
        int busy_n;
        bin_in = val;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        busy_n = 1;
        k = 0;
        while (k < 40) begin
            k++;
            if (k == poke_k) begin
                bin_in = poke_val;
                start  = poke_start;
            end
            step();
            start = 1'b0;
            if (done) break;
            if (busy) busy_n++;
        end
        check({tag, ".latency"}, 32'(k), 32'd16);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd16);
        check({tag, ".bcd"}, 32'(bcd_out), 32'(exp));
        for (int t = 0; t < tail; t++) begin
            step();
            check({tag, ".tail_done"}, 32'(done), 32'd0);
            check({tag, ".tail_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int extra;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        step();
        step();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.bcd", 32'(bcd_out), 32'd0);
        reset = 1'b0;
        step();

        run_conv("zero", 16'd0, 20'h00000, 0, 16'd0, 1'b0, 2);
        run_conv("max", 16'd65535, 20'h65535, 0, 16'd0, 1'b0, 2);
        run_conv("chg_in", 16'd1234, 20'h01234, 3, 16'd9, 1'b0, 1);
        run_conv("start_busy", 16'd4095, 20'h04095, 5, 16'd7, 1'b1, 3);
        run_conv("ten", 16'd10, 20'h00010, 0, 16'd0, 1'b0, 1);

        run_conv("b2b_a", 16'd42, 20'h00042, 0, 16'd0, 1'b0, 0);
        check("b2b_a.done", 32'(done), 32'd1);
        run_conv("b2b_b", 16'd9999, 20'h09999, 0, 16'd0, 1'b0, 1);

        bin_in = 16'd500;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("abort.busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.bcd", 32'(bcd_out), 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) extra++;
        end
        check("abort.quiet", 32'(extra), 32'd0);
        run_conv("after_abort", 16'd500, 20'h00500, 0, 16'd0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes the 16-bit value selected by the display multiplexer, converts it to five packed BCD digits and hands them to the seven-segment decoders. The conversion is iterative, one bit per clock, with a start/busy/done handshake.

## Interface

Parameters:
- `WIDTH`, default 16: binary input width.
- `DIGITS`, default 5: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH−1.

Clocking and reset (already decided): one clock, `clk`. Reset `reset` is synchronous and active-high.

Ports:
- `clk` input, 1: system clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high; returns the block to IDLE.
- `start` input, 1: request a conversion. Sampled only in IDLE.
- `bin_in` input, WIDTH: value to convert. Latched on an accepted `start`.
- `busy` output, 1: high while a conversion is in progress.
- `done` output, 1: single-cycle pulse when `bcd_out` has been updated.
- `bcd_out` output, 4*DIGITS: packed BCD, digit 0 (ones) in bits [3:0]. Holds the last result.

## Operation

States:
- **IDLE**
  - `start`=1 → latch `bin_in` into the shift register.
  - Clear the BCD scratch register to 0.
  - Clear the bit counter to 0.
  - Go to CONVERT.
- **CONVERT**, once per cycle:
  - Every scratch digit ≥5 gets +3; this is combinational.
  - Then shift {scratch, shift register} left by 1.
  - Increment the counter.
  - On the iteration where counter = WIDTH−1: load `bcd_out` with the post-shift scratch, set `done` for the next cycle, go to IDLE.

Arithmetic and widths:
- Each digit adjust is 4-bit: values 5..9 map to 8..12. Digits never exceed 9 after a shift.
- The counter is $clog2(WIDTH) bits.
- Scratch is 4*DIGITS bits; bits shifted out of the top digit are discarded (they cannot be nonzero given the DIGITS rule).

Output behaviour:
- `busy` = (state == CONVERT).
- `done` is registered: high for exactly one cycle after the final CONVERT edge, otherwise 0.
- `bcd_out` changes only on that final edge or on reset.

Boundary cases:
- `start` while busy: ignored. `bin_in` changes while busy are ignored.
- `start` held high continuously: a new conversion begins every WIDTH+1 cycles.
- `start` during the `done` cycle: the state is already IDLE, so it is accepted.
- `reset` mid-conversion: abort. Next cycle state=IDLE, `busy`=0, `done`=0, `bcd_out`=0, scratch and counter cleared.

Reset values: `busy`=0, `done`=0, `bcd_out`=0, state=IDLE.

## Timing

- `start` is sampled high at edge N.
- `busy` is high from edge N through edge N+WIDTH.
- `bcd_out` is valid and `done`=1 in the cycle after edge N+WIDTH (edge N+16 for the default WIDTH).
- Latency is WIDTH cycles from accept to result.
- Minimum start-to-start spacing is WIDTH+1 cycles.
- No combinational path from any input to any output.

## Structure

Shared package `display_pkg`:
- State enum `conv_state_t` {IDLE, CONVERT}.
- Constants `DISP_WIDTH`=16 and `BCD_DIGITS`=5, reused by the mux and the seven-segment stage.

Sub-module `bcd_digit_adjust`:
- Combinational 4-bit add-3-if-≥5.
- Instantiated DIGITS times with a generate loop.

Top level holds the FSM, counter and registers. Target size is about 150 RTL lines.

## Test plan

- **Reset, then zero:** reset for 2 cycles, then `start` with `bin_in`=16'd0. Expect `busy`=1 for 16 cycles, a `done` pulse, and `bcd_out`=20'h00000. All outputs are 0 during reset.
- **Maximum value:** `bin_in`=16'd65535. Expect `bcd_out`=20'h65535, `done` exactly 16 cycles after the start edge, and `done` high for exactly one cycle.
- **Typical value with input change:** `bin_in`=16'd1234, then change `bin_in` to 16'd9 during CONVERT. Expect `bcd_out`=20'h01234, since the input change is ignored.
- **Start while busy:** `start`=1 with 16'd4095, then pulse `start` at cycle 5 with 16'd7. Expect only one `done` and `bcd_out`=20'h04095.
- **Back-to-back:** assert `start` with 16'd9999 in the `done` cycle of the prior conversion. Expect `busy` to rise on that edge and `bcd_out`=20'h09999 16 cycles later.
- **Reset mid-conversion:** `reset` at cycle 8 of converting 16'd500. Expect `busy`=0, `done`=0 and `bcd_out`=0 next cycle, no `done` pulse afterward, and a subsequent conversion of 16'd500 giving 20'h00500.
